// File: rtl/theta_bus_if.sv
// Handshake and strobe bundle between theta requesters and theta_bus_ctrl.
// master = requester side, slave = controller side, mon = passive observer.
interface theta_bus_if #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
);
    logic                clear;
    logic                wr_req;
    logic [IDX_W-1:0]    wr_idx;
    logic                wr_ack;
    logic                rd_req_a;
    logic [IDX_W-1:0]    rd_idx_a;
    logic                rd_ack_a;
    logic                rd_req_b;
    logic [IDX_W-1:0]    rd_idx_b;
    logic                rd_ack_b;
    logic [NUM_REGS-1:0] load_en;
    logic [NUM_REGS-1:0] rd_en;
    logic [NUM_REGS-1:0] valid_mask;
    logic                busy;
    logic                err_idx;

    modport master (
        output clear, wr_req, wr_idx, rd_req_a, rd_idx_a, rd_req_b, rd_idx_b,
        input  wr_ack, rd_ack_a, rd_ack_b, load_en, rd_en, valid_mask, busy, err_idx
    );

    modport slave (
        input  clear, wr_req, wr_idx, rd_req_a, rd_idx_a, rd_req_b, rd_idx_b,
        output wr_ack, rd_ack_a, rd_ack_b, load_en, rd_en, valid_mask, busy, err_idx
    );

    modport mon (
        input clear, wr_req, wr_idx, rd_req_a, rd_idx_a, rd_req_b, rd_idx_b,
        input wr_ack, rd_ack_a, rd_ack_b, load_en, rd_en, valid_mask, busy, err_idx
    );
endinterface

// File: rtl/theta_bus_ctrl.sv
// Sequencer/arbiter for the shared theta bus: one writer, two round-robin readers.
// Optional macro THETA_BUS_TURNAROUND_EN inserts a dead TURN cycle after each read.
module theta_bus_ctrl #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic       clk,
    input  logic       rst,
    theta_bus_if.slave bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_TURN  = 2'd3;

    logic [1:0]          state_r,      state_nxt_s;
    logic                last_a_r,     last_a_nxt_s;
    logic                wr_ack_r,     wr_ack_nxt_s;
    logic                rd_ack_a_r,   rd_ack_a_nxt_s;
    logic                rd_ack_b_r,   rd_ack_b_nxt_s;
    logic [NUM_REGS-1:0] load_en_r,    load_en_nxt_s;
    logic [NUM_REGS-1:0] rd_en_r,      rd_en_nxt_s;
    logic [NUM_REGS-1:0] valid_mask_r, valid_mask_nxt_s;
    logic [NUM_REGS-1:0] valid_base_s;
    logic [NUM_REGS-1:0] rd_oh_s;
    logic                busy_r;
    logic                err_idx_r,    err_idx_nxt_s;
    logic                grant_a_s;

    // Out-of-range indices decode to all-zero, which doubles as the range check.
    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    // Arbitration and next-state/strobe computation; strobes are registered next edge.
    always_comb begin
        state_nxt_s    = state_r;
        last_a_nxt_s   = last_a_r;
        wr_ack_nxt_s   = 1'b0;
        rd_ack_a_nxt_s = 1'b0;
        rd_ack_b_nxt_s = 1'b0;
        load_en_nxt_s  = '0;
        rd_en_nxt_s    = '0;
        err_idx_nxt_s  = 1'b0;
        grant_a_s      = 1'b0;
        rd_oh_s        = '0;
        case (state_r)
            ST_IDLE: begin
                if (bus.wr_req) begin
                    state_nxt_s   = ST_WRITE;
                    wr_ack_nxt_s  = 1'b1;
                    load_en_nxt_s = idx_onehot(bus.wr_idx);
                    err_idx_nxt_s = ~|load_en_nxt_s;
                end else if (bus.rd_req_a || bus.rd_req_b) begin
                    if (bus.rd_req_a && bus.rd_req_b) begin
                        grant_a_s = ~last_a_r;
                    end else begin
                        grant_a_s = bus.rd_req_a;
                    end
                    rd_oh_s        = grant_a_s ? idx_onehot(bus.rd_idx_a) : idx_onehot(bus.rd_idx_b);
                    // Unwritten entries are never enabled, so the bus floats instead of driving stale data.
                    rd_en_nxt_s    = rd_oh_s & valid_mask_r;
                    err_idx_nxt_s  = ~|rd_en_nxt_s;
                    rd_ack_a_nxt_s = grant_a_s;
                    rd_ack_b_nxt_s = ~grant_a_s;
                    last_a_nxt_s   = grant_a_s;
                    state_nxt_s    = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WRITE: state_nxt_s = ST_IDLE;
`ifdef THETA_BUS_TURNAROUND_EN
            ST_READ:  state_nxt_s = ST_TURN;
`else
            ST_READ:  state_nxt_s = ST_IDLE;
`endif
            ST_TURN:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Clear takes effect first so a coinciding write still leaves its own bit set.
    always_comb begin
        valid_base_s     = bus.clear ? '0 : valid_mask_r;
        valid_mask_nxt_s = (state_r == ST_WRITE) ? (valid_base_s | load_en_r) : valid_base_s;
    end

    // State and registered outputs; reset drops every strobe immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_a_r     <= 1'b0;
            wr_ack_r     <= 1'b0;
            rd_ack_a_r   <= 1'b0;
            rd_ack_b_r   <= 1'b0;
            load_en_r    <= '0;
            rd_en_r      <= '0;
            valid_mask_r <= '0;
            busy_r       <= 1'b0;
            err_idx_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_a_r     <= last_a_nxt_s;
            wr_ack_r     <= wr_ack_nxt_s;
            rd_ack_a_r   <= rd_ack_a_nxt_s;
            rd_ack_b_r   <= rd_ack_b_nxt_s;
            load_en_r    <= load_en_nxt_s;
            rd_en_r      <= rd_en_nxt_s;
            valid_mask_r <= valid_mask_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            err_idx_r    <= err_idx_nxt_s;
        end
    end

    assign bus.wr_ack     = wr_ack_r;
    assign bus.rd_ack_a   = rd_ack_a_r;
    assign bus.rd_ack_b   = rd_ack_b_r;
    assign bus.load_en    = load_en_r;
    assign bus.rd_en      = rd_en_r;
    assign bus.valid_mask = valid_mask_r;
    assign bus.busy       = busy_r;
    assign bus.err_idx    = err_idx_r;
endmodule

// Bus-safety invariants for theta_bus_ctrl, instantiated alongside it in simulation.
module theta_bus_ctrl_chk (
    input logic      clk,
    input logic      rst,
    theta_bus_if.mon bus
);
    // One driver at most, one ack at most, and acks only outside IDLE.
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(bus.rd_en));
            assert ($onehot0(bus.load_en));
            assert ($onehot0({bus.wr_ack, bus.rd_ack_a, bus.rd_ack_b}));
            assert (!(bus.wr_ack || bus.rd_ack_a || bus.rd_ack_b) || bus.busy);
        end
    end
endmodule

// File: tb/tb_theta_bus_ctrl.sv
// Self-checking bench for theta_bus_ctrl: directed scenarios plus randomized
// request batches checked against a transaction-level model.
module tb_theta_bus_ctrl;
    localparam int NREG = 8;
`ifdef THETA_BUS_TURNAROUND_EN
    localparam int RD_GAP   = 3;
    localparam bit TURN_EN  = 1'b1;
`else
    localparam int RD_GAP   = 2;
    localparam bit TURN_EN  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    theta_bus_if #(.NUM_REGS(8), .IDX_W(3)) bus ();
    theta_bus_if #(.NUM_REGS(6), .IDX_W(3)) bus6 ();

    theta_bus_ctrl #(.NUM_REGS(8), .IDX_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    theta_bus_ctrl #(.NUM_REGS(6), .IDX_W(3)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
    theta_bus_ctrl_chk chk  (.clk(clk), .rst(rst), .bus(bus));
    theta_bus_ctrl_chk chk6 (.clk(clk), .rst(rst), .bus(bus6));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state: which entries hold data, and who was served last.
    logic [7:0] m_valid  = 8'h00;
    bit         m_last_a = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Raise a set of requests together from idle and follow every grant to completion.
    task automatic batch(input bit w, input logic [2:0] wi, input bit a, input logic [2:0] ai,
                         input bit b, input logic [2:0] bi, input bit clr);
        bit pw, pa, pb, got, ok;
        int kind, exp_cyc;
        logic [2:0] idx;
        logic [7:0] exp_oh;
        pw = w; pa = a; pb = b;
        bus.wr_req = w;   bus.wr_idx = wi;
        bus.rd_req_a = a; bus.rd_idx_a = ai;
        bus.rd_req_b = b; bus.rd_idx_b = bi;
        exp_cyc = cyc + 1;
        while (pw || pa || pb) begin
            if (pw) kind = 0;
            else if (pa && pb) kind = m_last_a ? 2 : 1;
            else if (pa) kind = 1;
            else kind = 2;
            idx = (kind == 0) ? wi : ((kind == 1) ? ai : bi);
            exp_oh = (int'(idx) < NREG) ? (8'h01 << idx) : 8'h00;
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                step();
                got = bus.wr_ack || bus.rd_ack_a || bus.rd_ack_b;
            end
            check("ack_seen", 32'(got), 32'd1);
            if (!got) begin
                bus.wr_req = 1'b0; bus.rd_req_a = 1'b0; bus.rd_req_b = 1'b0;
                return;
            end
            check("ack_cycle", 32'(cyc), 32'(exp_cyc));
            check("wr_ack", 32'(bus.wr_ack), 32'(kind == 0));
            check("rd_ack_a", 32'(bus.rd_ack_a), 32'(kind == 1));
            check("rd_ack_b", 32'(bus.rd_ack_b), 32'(kind == 2));
            check("busy_ack", 32'(bus.busy), 32'd1);
            if (kind == 0) begin
                check("load_en", 32'(bus.load_en), 32'(exp_oh));
                check("rd_en_wr", 32'(bus.rd_en), 32'd0);
                check("err_wr", 32'(bus.err_idx), 32'(exp_oh == 8'h00));
                pw = 1'b0; bus.wr_req = 1'b0;
                if (clr) bus.clear = 1'b1;
            end else begin
                ok = (exp_oh & m_valid) != 8'h00;
                check("rd_en", 32'(bus.rd_en), 32'(ok ? exp_oh : 8'h00));
                check("load_en_rd", 32'(bus.load_en), 32'd0);
                check("err_rd", 32'(bus.err_idx), 32'(!ok));
                m_last_a = (kind == 1);
                if (kind == 1) begin pa = 1'b0; bus.rd_req_a = 1'b0; end
                else begin pb = 1'b0; bus.rd_req_b = 1'b0; end
            end
            step();
            bus.clear = 1'b0;
            if (kind == 0) begin
                if (clr) m_valid = 8'h00;
                m_valid = m_valid | exp_oh;
            end
            check("acks_one_cycle", 32'({bus.wr_ack, bus.rd_ack_a, bus.rd_ack_b}), 32'd0);
            check("strobes_off", 32'({bus.load_en, bus.rd_en}), 32'd0);
            check("err_pulse", 32'(bus.err_idx), 32'd0);
            check("valid_mask", 32'(bus.valid_mask), 32'(m_valid));
            check("busy_after", 32'(bus.busy), 32'(kind != 0 && TURN_EN));
            exp_cyc = cyc - 1 + ((kind == 0) ? 2 : RD_GAP);
        end
        step();
        step();
        check("busy_idle", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit w, a, b, clr;
        bus.clear = 1'b0; bus.wr_req = 1'b0; bus.wr_idx = 3'd0;
        bus.rd_req_a = 1'b0; bus.rd_idx_a = 3'd0; bus.rd_req_b = 1'b0; bus.rd_idx_b = 3'd0;
        bus6.clear = 1'b0; bus6.wr_req = 1'b0; bus6.wr_idx = 3'd0;
        bus6.rd_req_a = 1'b0; bus6.rd_idx_a = 3'd0; bus6.rd_req_b = 1'b0; bus6.rd_idx_b = 3'd0;

        step(); step();
        rst = 1'b0;
        step();
        check("rst_outputs", 32'({bus.wr_ack, bus.rd_ack_a, bus.rd_ack_b, bus.busy, bus.err_idx}), 32'd0);
        check("rst_strobes", 32'({bus.load_en, bus.rd_en}), 32'd0);
        check("rst_valid", 32'(bus.valid_mask), 32'd0);

        batch(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        check("first_write_mask", 32'(bus.valid_mask), 32'h08);
        batch(1'b1, 3'd3, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
        batch(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b0);
        batch(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        batch(1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        batch(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        check("mask_0f", 32'(bus.valid_mask), 32'h0F);
        batch(1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b0);
        batch(1'b0, 3'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b0);
        batch(1'b1, 3'd2, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        check("clear_write_mask", 32'(bus.valid_mask), 32'h04);

        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        m_valid = 8'h00;
        check("idle_clear", 32'(bus.valid_mask), 32'(m_valid));

        for (int t = 0; t < 40; t++) begin
            w = 1'($urandom_range(0, 1));
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (!w && !b) a = 1'b1;
            clr = w && ($urandom_range(0, 3) == 0);
            batch(w, 3'($urandom_range(0, 7)), a, 3'($urandom_range(0, 7)),
                  b, 3'($urandom_range(0, 7)), clr);
            if ($urandom_range(0, 7) == 0) begin
                bus.clear = 1'b1;
                step();
                bus.clear = 1'b0;
                m_valid = 8'h00;
                check("rand_clear", 32'(bus.valid_mask), 32'(m_valid));
            end
        end

        batch(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        bus.rd_req_a = 1'b1; bus.rd_idx_a = 3'd0;
        step();
        check("pre_rst_ack", 32'(bus.rd_ack_a), 32'd1);
        check("pre_rst_rd_en", 32'(bus.rd_en), 32'h01);
        rst = 1'b1;
        #1;
        check("rst_drop_strobes", 32'({bus.rd_en, bus.load_en}), 32'd0);
        check("rst_drop_acks", 32'({bus.wr_ack, bus.rd_ack_a, bus.rd_ack_b}), 32'd0);
        bus.rd_req_a = 1'b0;
        m_valid = 8'h00;
        m_last_a = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        check("post_rst_valid", 32'(bus.valid_mask), 32'd0);
        batch(1'b0, 3'd0, 1'b1, 3'd4, 1'b1, 3'd6, 1'b0);

        bus6.wr_req = 1'b1; bus6.wr_idx = 3'd7;
        step();
        check("n6_wr_ack", 32'(bus6.wr_ack), 32'd1);
        check("n6_load_en", 32'(bus6.load_en), 32'd0);
        check("n6_err", 32'(bus6.err_idx), 32'd1);
        bus6.wr_req = 1'b0;
        step();
        check("n6_mask", 32'(bus6.valid_mask), 32'd0);
        step();
        bus6.rd_req_b = 1'b1; bus6.rd_idx_b = 3'd5;
        step();
        check("n6_rd_ack_b", 32'(bus6.rd_ack_b), 32'd1);
        check("n6_rd_en", 32'(bus6.rd_en), 32'd0);
        check("n6_rd_err", 32'(bus6.err_idx), 32'd1);
        bus6.rd_req_b = 1'b0;
        step(); step(); step();
        bus6.wr_req = 1'b1; bus6.wr_idx = 3'd5;
        step();
        check("n6_load_5", 32'(bus6.load_en), 32'h20);
        bus6.wr_req = 1'b0;
        step();
        check("n6_mask_5", 32'(bus6.valid_mask), 32'h20);
        step();
        bus6.rd_req_a = 1'b1; bus6.rd_idx_a = 3'd5;
        step();
        check("n6_rd_en_5", 32'(bus6.rd_en), 32'h20);
        check("n6_rd_ok", 32'(bus6.err_idx), 32'd0);
        bus6.rd_req_a = 1'b0;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/theta_bus_ctrl.md
Name: theta_bus_ctrl

Overview:
- Sequences a bank of NUM_REGS theta register-file entries that share one tri-state theta bus.
- Arbitrates one write requester (LS solver output) against two read requesters: A = residual update, B = final output.
- Generates one-hot load_en/rd_en strobes, so at most one entry ever drives the bus.
- Tracks which entries hold a valid theta for the current OMP iteration.

Parameters:
NUM_REGS, 8, number of theta entries on the bus
IDX_W, 3, index width; must satisfy 2**IDX_W >= NUM_REGS

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clear  in  1  one-cycle pulse; clears valid_mask (new OMP run)
wr_req  in  1  write request, held until wr_ack
wr_idx  in  IDX_W  target entry, stable while wr_req
wr_ack  out  1  one-cycle; load_en is active this cycle, requester drives din
rd_req_a  in  1  read request A, held until rd_ack_a
rd_idx_a  in  IDX_W  entry for A
rd_ack_a  out  1  one-cycle; bus data valid this cycle
rd_req_b  in  1  read request B
rd_idx_b  in  IDX_W  entry for B
rd_ack_b  out  1  one-cycle; bus data valid this cycle
load_en  out  NUM_REGS  one-hot load strobe to entries
rd_en  out  NUM_REGS  one-hot bus-drive enable to entries
valid_mask  out  NUM_REGS  bit i set = entry i written since last clear
busy  out  1  high when state != IDLE
err_idx  out  1  one-cycle pulse on an out-of-range or unwritten access

Behaviour:
- Reset: state IDLE; all outputs 0; RR pointer favours A. Reset mid-operation aborts the transfer with no ack, and strobes drop immediately.
- FSM states: IDLE, WRITE, READ, TURN. All outputs are registered.
- IDLE arbitration (cycle 0):
  - wr_req beats any read.
  - Otherwise, if a single read is pending, it is granted.
  - If both reads are pending, grant the requester not granted last (round-robin); update the pointer on grant.
  - Latch the granted index and requester.
- WRITE (cycle 1):
  - load_en[idx]=1 and wr_ack=1 for exactly one cycle.
  - Set valid_mask[idx].
  - Next state IDLE.
- READ (cycle 1):
  - rd_en[idx]=1 and the granted rd_ack=1 for exactly one cycle.
  - Next state TURN (or IDLE, see Optional Feature).
- TURN: all strobes 0 for one cycle, then IDLE.
- Latency and throughput:
  - Request to ack is 1 cycle when the controller is idle.
  - Back-to-back writes: one every 2 cycles.
  - Back-to-back reads: one every 3 cycles.
- Index boundaries:
  - wr_idx >= NUM_REGS: wr_ack still issued, load_en stays 0, err_idx pulses with the ack, valid_mask unchanged.
  - Read of an index >= NUM_REGS, or with valid_mask bit 0: ack still issued, rd_en stays 0 (bus floats z), err_idx pulses with the ack.
- clear:
  - Zeroes valid_mask next cycle.
  - If clear coincides with WRITE, clear applies first, then the written bit is set (write wins).
  - clear does not abort an in-flight transfer.
- Invariants (checked by assertion):
  - rd_en and load_en are each 0 or one-hot.
  - Never more than one ack per cycle.
  - No acks while in IDLE.
- A request withdrawn before its ack is a protocol violation; behaviour is undefined.

Optional Feature:
- Macro THETA_BUS_TURNAROUND_EN.
- Defined: READ is always followed by one TURN cycle with all rd_en=0, giving a dead cycle between bus drivers.
- Undefined: TURN state is removed; READ returns directly to IDLE, and back-to-back reads take 2 cycles.
- Write timing is identical in both builds.

Test Plan:
- Reset, then wr_req with wr_idx=3 -> 1 cycle later load_en=8'b0000_1000 and wr_ack=1 for one cycle; valid_mask=8'h08.
- wr_req and rd_req_a (idx 3) raised together -> write acked first, then the read. rd_en=8'h08 with rd_ack_a; TURN cycle shows rd_en=0 when THETA_BUS_TURNAROUND_EN is defined.
- Entries 0..1 written; rd_req_a (idx 0) and rd_req_b (idx 1) held for 4 grants -> ack order A,B,A,B; rd_en alternates 8'h01 / 8'h02 and is never two-hot.
- rd_req_b for idx 5 never written -> rd_ack_b=1, rd_en=0, err_idx=1. wr_idx=7 with NUM_REGS=6 -> wr_ack=1, load_en=0, err_idx=1.
- clear in the same cycle as WRITE to idx 2, with valid_mask=8'h0F beforehand -> valid_mask=8'h04 afterwards.
- rst asserted during READ -> rd_en and all acks drop to 0 immediately; after release state is IDLE and valid_mask=0.
